// File: rtl/collision_matrix.sv
// Per-frame collision detector between two groups of drawn objects.
// Each object is flagged at most once per frame; pulses are immediate or deferred to the frame end.
module collision_matrix #(
  parameter int unsigned NUM_A    = 4,
  parameter int unsigned NUM_B    = 8,
  parameter int unsigned DEFERRED = 0,
  parameter int unsigned CNT_W    = 5
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startOfFrame,
  input  logic [NUM_A-1:0] a_request,
  input  logic [NUM_B-1:0] b_request,
  input  logic [NUM_A-1:0] a_enable,
  input  logic [NUM_B-1:0] b_enable,
  output logic [NUM_A-1:0] hit_pulse_a,
  output logic [NUM_B-1:0] hit_pulse_b,
  output logic             any_hit,
  output logic [CNT_W-1:0] hit_count
);

  localparam int unsigned CntMax = (1 << CNT_W) - 1;

  typedef enum logic [0:0] {StCollect, StIssue} state_e;

  state_e           state_q;
  logic [NUM_A-1:0] flag_a_q, pulse_a_q;
  logic [NUM_B-1:0] flag_b_q, pulse_b_q;
  logic             any_hit_q;
  logic [CNT_W-1:0] hit_count_q;

  logic [NUM_A-1:0] act_a, col_a, new_a;
  logic [NUM_B-1:0] act_b, col_b, new_b;
  logic [CNT_W-1:0] sat_count;
  int unsigned      pop_a;

  assign act_a = a_request & a_enable;
  assign act_b = b_request & b_enable;

  // The OR over all pairs reduces to "I am active and anyone on the other side is active".
  always_comb begin
    col_a = act_a & {NUM_A{|act_b}};
    col_b = act_b & {NUM_B{|act_a}};
    new_a = startOfFrame ? col_a : (col_a & ~flag_a_q);
    new_b = startOfFrame ? col_b : (col_b & ~flag_b_q);
  end

  always_comb begin
    pop_a = 0;
    for (int i = 0; i < int'(NUM_A); i++) begin
      pop_a = pop_a + 32'(flag_a_q[i]);
    end
    sat_count = (pop_a > CntMax) ? CNT_W'(CntMax) : CNT_W'(pop_a);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= StCollect;
      flag_a_q    <= '0;
      flag_b_q    <= '0;
      pulse_a_q   <= '0;
      pulse_b_q   <= '0;
      any_hit_q   <= 1'b0;
      hit_count_q <= '0;
    end else begin
      // A collision in the SOF cycle already belongs to the new frame.
      if (startOfFrame) begin
        flag_a_q    <= col_a;
        flag_b_q    <= col_b;
        hit_count_q <= sat_count;
      end else begin
        flag_a_q <= flag_a_q | col_a;
        flag_b_q <= flag_b_q | col_b;
      end

      if (DEFERRED != 0) begin
        // Pulse registers double as the frame snapshot shown during ISSUE.
        if (startOfFrame) begin
          pulse_a_q <= flag_a_q;
          pulse_b_q <= flag_b_q;
          any_hit_q <= |flag_a_q;
          state_q   <= StIssue;
        end else if (state_q == StIssue) begin
          pulse_a_q <= '0;
          pulse_b_q <= '0;
          any_hit_q <= 1'b0;
          state_q   <= StCollect;
        end
      end else begin
        pulse_a_q <= new_a;
        pulse_b_q <= new_b;
        any_hit_q <= |new_a;
        state_q   <= StCollect;
      end
    end
  end

  assign hit_pulse_a = pulse_a_q;
  assign hit_pulse_b = pulse_b_q;
  assign any_hit     = any_hit_q;
  assign hit_count   = hit_count_q;

endmodule

// File: tb/tb_collision_matrix.sv
// Bench for collision_matrix: immediate, deferred and narrow-counter instances share one stimulus
// stream and are checked every cycle against a frame-level model.
module tb_collision_matrix;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic [3:0] a_request = '0, a_enable = '1;
  logic [7:0] b_request = '0, b_enable = '1;

  logic [3:0] pa0, pa1, pa2;
  logic [7:0] pb0, pb1, pb2;
  logic       any0, any1, any2;
  logic [4:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  collision_matrix #(.NUM_A(4), .NUM_B(8), .DEFERRED(0), .CNT_W(5)) dut0 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .a_request(a_request), .b_request(b_request), .a_enable(a_enable), .b_enable(b_enable),
    .hit_pulse_a(pa0), .hit_pulse_b(pb0), .any_hit(any0), .hit_count(cnt0)
  );

  collision_matrix #(.NUM_A(4), .NUM_B(8), .DEFERRED(1), .CNT_W(5)) dut1 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .a_request(a_request), .b_request(b_request), .a_enable(a_enable), .b_enable(b_enable),
    .hit_pulse_a(pa1), .hit_pulse_b(pb1), .any_hit(any1), .hit_count(cnt1)
  );

  collision_matrix #(.NUM_A(4), .NUM_B(8), .DEFERRED(0), .CNT_W(2)) dut2 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .a_request(a_request), .b_request(b_request), .a_enable(a_enable), .b_enable(b_enable),
    .hit_pulse_a(pa2), .hit_pulse_b(pb2), .any_hit(any2), .hit_count(cnt2)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, required %0h", nm, $time, got, exp);
    end
  endtask

  // Frame-level model: set of objects hit so far this frame, per instance.
  logic [3:0] m_fa[3];
  logic [7:0] m_fb[3];
  logic [3:0] exp_pa[3];
  logic [7:0] exp_pb[3];
  logic       exp_any[3];
  int         exp_cnt[3];
  int         cnt_max[3] = '{31, 31, 3};
  bit         is_def[3] = '{1'b0, 1'b1, 1'b0};

  always @(posedge clk or negedge resetN) begin : model
    logic [3:0] ca;
    logic [7:0] cb;
    int n;
    if (!resetN) begin
      for (int k = 0; k < 3; k++) begin
        m_fa[k] = '0; m_fb[k] = '0; exp_pa[k] = '0; exp_pb[k] = '0;
        exp_any[k] = 1'b0; exp_cnt[k] = 0;
      end
    end else begin
      ca = '0;
      cb = '0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 8; j++)
          if (a_request[i] && a_enable[i] && b_request[j] && b_enable[j]) begin
            ca[i] = 1'b1;
            cb[j] = 1'b1;
          end
      for (int k = 0; k < 3; k++) begin
        if (startOfFrame) begin
          n = 0;
          for (int i = 0; i < 4; i++) n += int'(m_fa[k][i]);
          exp_cnt[k] = (n > cnt_max[k]) ? cnt_max[k] : n;
        end
        if (is_def[k]) begin
          exp_pa[k] = startOfFrame ? m_fa[k] : 4'h0;
          exp_pb[k] = startOfFrame ? m_fb[k] : 8'h0;
        end else begin
          exp_pa[k] = startOfFrame ? ca : (ca & ~m_fa[k]);
          exp_pb[k] = startOfFrame ? cb : (cb & ~m_fb[k]);
        end
        exp_any[k] = |exp_pa[k];
        m_fa[k] = startOfFrame ? ca : (m_fa[k] | ca);
        m_fb[k] = startOfFrame ? cb : (m_fb[k] | cb);
      end
    end
  end

  always @(negedge clk) begin
    chk("d0_pulse_a", pa0, exp_pa[0]);   chk("d0_pulse_b", pb0, exp_pb[0]);
    chk("d0_any_hit", any0, exp_any[0]); chk("d0_hit_count", cnt0, exp_cnt[0]);
    chk("d1_pulse_a", pa1, exp_pa[1]);   chk("d1_pulse_b", pb1, exp_pb[1]);
    chk("d1_any_hit", any1, exp_any[1]); chk("d1_hit_count", cnt1, exp_cnt[1]);
    chk("d2_pulse_a", pa2, exp_pa[2]);   chk("d2_pulse_b", pb2, exp_pb[2]);
    chk("d2_any_hit", any2, exp_any[2]); chk("d2_hit_count", cnt2, exp_cnt[2]);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [3:0] a, input logic [7:0] b);
    a_request = a;
    b_request = b;
  endtask

  task automatic sof_pulse();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  initial begin
    int sof_gap;
    repeat (3) tick();
    chk("reset_pulse_a", pa0, 4'h0);
    chk("reset_count", cnt0, 5'd0);
    resetN = 1'b1;
    tick();
    sof_pulse();
    chk("first_sof_count", cnt0, 5'd0);

    // Single pair, immediate pulse one cycle after first overlap only.
    drive(4'b0100, 8'h20);
    tick();
    chk("single_pulse_a", pa0, 4'b0100);
    chk("single_pulse_b", pb0, 8'h20);
    tick();
    chk("single_no_repeat", pa0, 4'h0);
    repeat (8) tick();
    drive(4'h0, 8'h00);
    tick();
    sof_pulse();
    chk("single_count", cnt0, 5'd1);
    chk("single_deferred", pa1, 4'b0100);
    tick();
    chk("deferred_one_cycle", pa1, 4'h0);
    drive(4'b0100, 8'h20);
    tick();
    chk("second_frame_pulse", pa0, 4'b0100);
    drive(4'h0, 8'h00);
    tick();

    // Masked object never collides; re-enabling mid-overlap pulses.
    sof_pulse();
    a_enable = 4'b1011;
    drive(4'b0100, 8'h20);
    repeat (3) tick();
    chk("masked_no_pulse", pa0, 4'h0);
    drive(4'h0, 8'h00);
    sof_pulse();
    chk("masked_count", cnt0, 5'd0);
    drive(4'b0100, 8'h20);
    repeat (2) tick();
    a_enable = 4'hf;
    tick();
    chk("reenable_pulse", pa0, 4'b0100);
    drive(4'h0, 8'h00);
    tick();

    // Multi-pair overlap.
    sof_pulse();
    drive(4'b0011, 8'h03);
    tick();
    chk("multi_pulse_a", pa0, 4'b0011);
    chk("multi_pulse_b", pb0, 8'h03);
    drive(4'h0, 8'h00);
    tick();
    sof_pulse();
    chk("multi_count", cnt0, 5'd2);

    // SOF coincident with an overlap already flagged this frame.
    drive(4'b0100, 8'h20);
    repeat (2) tick();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    chk("sof_coincident", pa0, 4'b0100);
    drive(4'h0, 8'h00);
    tick();

    // Deferred: hits at different times issued together after SOF.
    sof_pulse();
    drive(4'b0001, 8'h01);
    tick();
    chk("deferred_quiet_1", pa1, 4'h0);
    drive(4'h0, 8'h00);
    repeat (20) tick();
    drive(4'b1000, 8'h02);
    tick();
    chk("deferred_quiet_2", pa1, 4'h0);
    drive(4'h0, 8'h00);
    tick();
    sof_pulse();
    chk("deferred_pulse_a", pa1, 4'b1001);
    chk("deferred_pulse_b", pb1, 8'h03);
    chk("deferred_any", any1, 1'b1);
    chk("deferred_count", cnt1, 5'd2);
    tick();
    chk("deferred_done", pa1, 4'h0);

    // Saturation on the 2-bit counter.
    drive(4'b1111, 8'h01);
    tick();
    drive(4'h0, 8'h00);
    tick();
    sof_pulse();
    chk("sat_count_w2", cnt2, 2'd3);
    chk("sat_count_w5", cnt0, 5'd4);

    // Back-to-back SOF: each SOF re-snapshots.
    drive(4'b0010, 8'h04);
    tick();
    drive(4'h0, 8'h00);
    tick();
    startOfFrame = 1'b1;
    drive(4'b0100, 8'h08);
    tick();
    chk("b2b_first", pa1, 4'b0010);
    drive(4'b1000, 8'h80);
    tick();
    chk("b2b_second", pa1, 4'b0100);
    startOfFrame = 1'b0;
    drive(4'h0, 8'h00);
    tick();
    chk("b2b_after", pa1, 4'h0);

    // Asynchronous reset mid-frame, right after a pulse.
    sof_pulse();
    drive(4'b0100, 8'h20);
    tick();
    resetN = 1'b0;
    #1;
    chk("async_rst_pulse_a", pa0, 4'h0);
    chk("async_rst_pulse_b", pb0, 8'h00);
    chk("async_rst_any", any0, 1'b0);
    chk("async_rst_count", cnt0, 5'd0);
    drive(4'h0, 8'h00);
    tick();
    resetN = 1'b1;
    tick();
    chk("post_rst_quiet", pa0, 4'h0);
    drive(4'b0100, 8'h20);
    tick();
    chk("post_rst_pulse", pa0, 4'b0100);
    drive(4'h0, 8'h00);

    // Randomised frames with sparse requests and mostly-on enables.
    sof_gap = 1;
    for (int c = 0; c < 4000; c++) begin
      a_request    = 4'($urandom) & 4'($urandom);
      b_request    = 8'($urandom) & 8'($urandom) & 8'($urandom);
      a_enable     = 4'($urandom) | 4'($urandom) | 4'($urandom);
      b_enable     = 8'($urandom) | 8'($urandom);
      sof_gap--;
      startOfFrame = (sof_gap == 0);
      if (sof_gap == 0) sof_gap = ($urandom_range(0, 9) == 0) ? 1 : int'($urandom_range(2, 60));
      tick();
    end
    startOfFrame = 1'b0;
    drive(4'h0, 8'h00);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
